// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl
// Main sequencer for an in-place radix-2 DIT FFT datapath. One run has three
// phases: load N samples into SRAM, run LOG2N stages of N/2 butterflies, then
// unload N samples. SRAM addresses, the twiddle index and the stage number all
// come from internal counters.
//
// Parameters
//   LOG2N   log2 of the FFT size, N = 1<<LOG2N (N >= 4)
//   BF_LAT  butterfly latency in cycles, from bfly_ena to result valid (>= 1)
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   fft_start                start request, sampled only while idle
//   in_valid / out_ready     input buffer has data / output buffer has room
//   sram_addr, sram_read_ena, sram_write_ena   SRAM word address and strobes
//   shift_in_ena / shift_out_ena               input pop / output push
//   addr_mode                0 idle, 1 load, 2 butterfly, 3 unload
//   bfly_ena, bfly_sel       butterfly start pulse, operand A(0)/B(1) select
//   twiddle_k, stage         twiddle index and stage of the current butterfly
//   busy, fft_done           not idle / one-cycle completion pulse
//
// Build option: define FFT_CTRL_BITREV_EN to bit-reverse the load address.
// When it is undefined the unload address is bit-reversed instead. Output
// order is natural in both builds.
//
// Every output is a register. A state's action shows up in the cycle after
// the edge at which the state is evaluated, so address and strobes stay
// aligned.
// -----------------------------------------------------------------------------
module fft_seq_ctrl #(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fft_start,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic [LOG2N-1:0]           sram_addr,
  output logic                       sram_read_ena,
  output logic                       sram_write_ena,
  output logic                       shift_in_ena,
  output logic                       shift_out_ena,
  output logic [1:0]                 addr_mode,
  output logic                       bfly_ena,
  output logic                       bfly_sel,
  output logic [LOG2N-2:0]           twiddle_k,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       busy,
  output logic                       fft_done
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int CW = LOG2N + 1;
  localparam int WW = (BF_LAT > 2) ? $clog2(BF_LAT - 1) : 1;

  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    LD_LAST = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_N   = CW'(N);
  localparam logic [KW-1:0]    B_ONE   = KW'(1);
  localparam logic [KW-1:0]    B_LAST  = KW'(N / 2 - 1);
  localparam logic [SW-1:0]    S_ONE   = SW'(1);
  localparam logic [SW-1:0]    S_LAST  = SW'(LOG2N - 1);
  localparam logic [WW-1:0]    W_ONE   = WW'(1);
  localparam logic [WW-1:0]    W_LAST  = WW'(BF_LAT - 2);
  localparam logic [LOG2N-1:0] A_ONE   = LOG2N'(1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_LOAD   = 4'd1;
  localparam logic [3:0] ST_RD_A   = 4'd2;
  localparam logic [3:0] ST_RD_B   = 4'd3;
  localparam logic [3:0] ST_WAIT   = 4'd4;
  localparam logic [3:0] ST_WR_A   = 4'd5;
  localparam logic [3:0] ST_WR_B   = 4'd6;
  localparam logic [3:0] ST_NEXT   = 4'd7;
  localparam logic [3:0] ST_UNLOAD = 4'd8;

  logic [3:0]       state_r;
  logic [CW-1:0]    ld_cnt_r;
  logic [CW-1:0]    ul_cnt_r;
  logic [KW-1:0]    b_r;
  logic [SW-1:0]    s_r;
  logic [WW-1:0]    wait_r;

  logic [LOG2N-1:0] b_ext_s;
  logic [LOG2N-1:0] span_s;
  logic [LOG2N-1:0] pos_s;
  logic [LOG2N-1:0] top_s;
  logic [LOG2N-1:0] bot_s;
  logic [KW-1:0]    k_s;
  logic [1:0]       mode_s;
  logic             bf_state_s;
  logic [LOG2N-1:0] ld_addr_s;
  logic [LOG2N-1:0] ul_addr_s;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

`ifdef FFT_CTRL_BITREV_EN
  assign ld_addr_s = bit_rev(ld_cnt_r[LOG2N-1:0]);
  assign ul_addr_s = ul_cnt_r[LOG2N-1:0];
`else
  assign ld_addr_s = ld_cnt_r[LOG2N-1:0];
  assign ul_addr_s = bit_rev(ul_cnt_r[LOG2N-1:0]);
`endif

  // Butterfly operand addresses and twiddle index from (b, s).
  // Bit s of top is always 0, so bot = top + span reduces to an OR.
  always_comb begin
    b_ext_s = {1'b0, b_r};
    span_s  = A_ONE << s_r;
    pos_s   = b_ext_s & (span_s - A_ONE);
    top_s   = (((b_ext_s >> s_r) << s_r) << 1'b1) | pos_s;
    bot_s   = top_s | span_s;
    k_s     = KW'(pos_s << (S_LAST - s_r));
  end

  // Address mode for the state being evaluated, and whether it is a butterfly phase.
  always_comb begin
    mode_s     = 2'd0;
    bf_state_s = 1'b0;
    case (state_r)
      ST_IDLE:   mode_s = 2'd0;
      ST_LOAD:   mode_s = 2'd1;
      ST_RD_A, ST_RD_B, ST_WAIT, ST_WR_A, ST_WR_B, ST_NEXT: begin
        mode_s     = 2'd2;
        bf_state_s = 1'b1;
      end
      ST_UNLOAD: mode_s = 2'd3;
      default:   mode_s = 2'd0;
    endcase
  end

  // Sequencer: state, counters and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      ld_cnt_r       <= '0;
      ul_cnt_r       <= '0;
      b_r            <= '0;
      s_r            <= '0;
      wait_r         <= '0;
      sram_addr      <= '0;
      sram_read_ena  <= 1'b0;
      sram_write_ena <= 1'b0;
      shift_in_ena   <= 1'b0;
      shift_out_ena  <= 1'b0;
      addr_mode      <= 2'd0;
      bfly_ena       <= 1'b0;
      bfly_sel       <= 1'b0;
      twiddle_k      <= '0;
      stage          <= '0;
      busy           <= 1'b0;
      fft_done       <= 1'b0;
    end else begin
      sram_addr      <= '0;
      sram_read_ena  <= 1'b0;
      sram_write_ena <= 1'b0;
      shift_in_ena   <= 1'b0;
      bfly_ena       <= 1'b0;
      bfly_sel       <= 1'b0;
      fft_done       <= 1'b0;
      twiddle_k      <= '0;
      stage          <= '0;
      addr_mode      <= mode_s;
      busy           <= (state_r != ST_IDLE);
      // Each unload read yields data one cycle later; push it unconditionally.
      shift_out_ena  <= sram_read_ena & (addr_mode == 2'd3);
      if (bf_state_s) begin
        twiddle_k <= k_s;
        stage     <= s_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (fft_start) begin
            state_r  <= ST_LOAD;
            ld_cnt_r <= '0;
            ul_cnt_r <= '0;
            b_r      <= '0;
            s_r      <= '0;
            wait_r   <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            shift_in_ena   <= 1'b1;
            sram_write_ena <= 1'b1;
            sram_addr      <= ld_addr_s;
            ld_cnt_r       <= ld_cnt_r + CNT_ONE;
            if (ld_cnt_r == LD_LAST) begin
              state_r <= ST_RD_A;
              b_r     <= '0;
              s_r     <= '0;
            end
          end
        end
        ST_RD_A: begin
          sram_read_ena <= 1'b1;
          sram_addr     <= top_s;
          state_r       <= ST_RD_B;
        end
        ST_RD_B: begin
          sram_read_ena <= 1'b1;
          sram_addr     <= bot_s;
          bfly_sel      <= 1'b1;
          bfly_ena      <= 1'b1;
          wait_r        <= '0;
          state_r       <= (BF_LAT > 1) ? ST_WAIT : ST_WR_A;
        end
        ST_WAIT: begin
          if (wait_r == W_LAST) begin
            state_r <= ST_WR_A;
          end else begin
            wait_r <= wait_r + W_ONE;
          end
        end
        ST_WR_A: begin
          sram_write_ena <= 1'b1;
          sram_addr      <= top_s;
          state_r        <= ST_WR_B;
        end
        ST_WR_B: begin
          sram_write_ena <= 1'b1;
          sram_addr      <= bot_s;
          bfly_sel       <= 1'b1;
          state_r        <= ST_NEXT;
        end
        // Turnaround cycle between butterflies; advances b and s.
        ST_NEXT: begin
          if (b_r == B_LAST) begin
            b_r <= '0;
            if (s_r == S_LAST) begin
              state_r <= ST_UNLOAD;
            end else begin
              s_r     <= s_r + S_ONE;
              state_r <= ST_RD_A;
            end
          end else begin
            b_r     <= b_r + B_ONE;
            state_r <= ST_RD_A;
          end
        end
        ST_UNLOAD: begin
          if (out_ready && (ul_cnt_r < CNT_N)) begin
            sram_read_ena <= 1'b1;
            sram_addr     <= ul_addr_s;
            ul_cnt_r      <= ul_cnt_r + CNT_ONE;
          end else if ((ul_cnt_r == CNT_N) && !sram_read_ena && shift_out_ena) begin
            // The last word is being shifted out this cycle.
            fft_done <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;
  localparam int LOG2N  = 3;
  localparam int BF_LAT = 2;
  localparam int N      = 1 << LOG2N;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       fft_start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] sram_addr;
  logic       sram_read_ena, sram_write_ena, shift_in_ena, shift_out_ena;
  logic [1:0] addr_mode;
  logic       bfly_ena, bfly_sel;
  logic [1:0] twiddle_k;
  logic [1:0] stage;
  logic       busy, fft_done;

  fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk(tb_clk), .rst(rst), .fft_start(fft_start), .in_valid(in_valid),
    .out_ready(out_ready), .sram_addr(sram_addr), .sram_read_ena(sram_read_ena),
    .sram_write_ena(sram_write_ena), .shift_in_ena(shift_in_ena),
    .shift_out_ena(shift_out_ena), .addr_mode(addr_mode), .bfly_ena(bfly_ena),
    .bfly_sel(bfly_sel), .twiddle_k(twiddle_k), .stage(stage), .busy(busy),
    .fft_done(fft_done)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    bit wr;
    int addr;
    bit sel;
    int k;
    int stg;
    int mode;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  failures = 0;

  // monitor-owned state
  int  cyc_n = 0, mode2_total = 0, so_total = 0, bf_total = 0, ldw_total = 0, done_total = 0;
  int  ld_first = 0, ld_last = 0, last_bfly_cyc = 0, cur_k = 0, cur_stg = 0;
  bit  prev_iv = 0, prev_or = 0, prev_ul_rd = 0, prev_last_so = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int rev(input int i);
    int r = 0;
    for (int j = 0; j < LOG2N; j++) r = (r << 1) | ((i >> j) & 1);
    return r;
  endfunction

  // Reference model: the ordered list of SRAM accesses one FFT run must make.
  function automatic void push_expected();
    ev_t e;
    for (int i = 0; i < N; i++) begin
`ifdef FFT_CTRL_BITREV_EN
      e = '{1'b1, rev(i), 1'b0, 0, 0, 1};
`else
      e = '{1'b1, i, 1'b0, 0, 0, 1};
`endif
      exp_q.push_back(e);
    end
    for (int s = 0; s < LOG2N; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        int span = 1 << s;
        int pos  = b % span;
        int top  = (b / span) * 2 * span + pos;
        int bot  = top + span;
        int k    = pos * ((N / 2) / span);
        exp_q.push_back('{1'b0, top, 1'b0, k, s, 2});
        exp_q.push_back('{1'b0, bot, 1'b1, k, s, 2});
        exp_q.push_back('{1'b1, top, 1'b0, k, s, 2});
        exp_q.push_back('{1'b1, bot, 1'b1, k, s, 2});
      end
    end
    for (int i = 0; i < N; i++) begin
`ifdef FFT_CTRL_BITREV_EN
      e = '{1'b0, i, 1'b0, 0, 0, 3};
`else
      e = '{1'b0, rev(i), 1'b0, 0, 0, 3};
`endif
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: pops the scoreboard on every SRAM access and checks protocol timing.
  always @(negedge tb_clk) begin
    if (rst) begin
      prev_iv = 0; prev_or = 0; prev_ul_rd = 0; prev_last_so = 0;
    end else begin
      cyc_n++;
      if (sram_write_ena || sram_read_ena) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access_qsize", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("acc_write", sram_write_ena, mon_e.wr);
          chk("acc_read", sram_read_ena, !mon_e.wr);
          chk("acc_addr", sram_addr, mon_e.addr);
          chk("acc_mode", addr_mode, mon_e.mode);
          if (mon_e.mode == 1) begin
            chk("shift_in_with_write", shift_in_ena, 1);
            chk("write_needs_in_valid", prev_iv, 1);
            if (ldw_total % N == 0) ld_first = cyc_n;
            ld_last = cyc_n;
            ldw_total++;
          end else if (mon_e.mode == 2) begin
            chk("bfly_sel", bfly_sel, mon_e.sel);
            chk("bfly_k", twiddle_k, mon_e.k);
            chk("bfly_stage", stage, mon_e.stg);
            chk("bfly_ena_on_rd_b", bfly_ena, (!mon_e.wr && mon_e.sel));
            if (!mon_e.wr && mon_e.sel) last_bfly_cyc = cyc_n;
            if (!mon_e.wr && !mon_e.sel) begin
              cur_k = mon_e.k;
              cur_stg = mon_e.stg;
            end
            if (mon_e.wr && !mon_e.sel) chk("rd_b_to_wr_a", cyc_n - last_bfly_cyc, BF_LAT);
          end else begin
            chk("read_needs_out_ready", prev_or, 1);
          end
        end
      end
      if (addr_mode == 2'd2) begin
        mode2_total++;
        chk("k_held", twiddle_k, cur_k);
        chk("stage_held", stage, cur_stg);
      end
      if (bfly_ena) bf_total++;
      if (shift_in_ena) chk("shift_in_align", (sram_write_ena && addr_mode == 2'd1), 1);
      chk("shift_out_timing", shift_out_ena, prev_ul_rd);
      chk("done_timing", fft_done, prev_last_so);
      if (shift_out_ena) so_total++;
      if (fft_done) done_total++;
      prev_last_so = shift_out_ena && (so_total % N == 0);
      prev_ul_rd   = sram_read_ena && (addr_mode == 2'd3);
      prev_iv      = in_valid;
      prev_or      = out_ready;
    end
  end

  function automatic int all_outs();
    return int'({sram_addr, sram_read_ena, sram_write_ena, shift_in_ena, shift_out_ena,
                 addr_mode, bfly_ena, bfly_sel, twiddle_k, stage, busy, fft_done});
  endfunction

  // iv_mode: 0 continuous, 1 alternating, 2 random.
  // or_mode: 0 always ready, 1 random, 2 three-cycle stall mid-unload.
  task automatic run_fft(input int iv_mode, input int or_mode, input bit glitch);
    int t, ones, j, jf, jl, m2_0, so_0, bf_0, dn_0, ldw_0;
    bit v;
    chk("idle_before_start_busy", busy, 0);
    push_expected();
    m2_0 = mode2_total; so_0 = so_total; bf_0 = bf_total; dn_0 = done_total; ldw_0 = ldw_total;
    fft_start = 1'b1;
    @(posedge tb_clk); #1;
    fft_start = 1'b0;
    ones = 0; j = 0; jf = -1; jl = 0;
    while (ones < N && j < 200) begin
      case (iv_mode)
        0:       v = 1'b1;
        1:       v = (j % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      if (v) begin
        if (jf < 0) jf = j;
        jl = j;
        ones++;
      end
      j++;
      @(posedge tb_clk); #1;
    end
    t = 0;
    while (addr_mode != 2'd3 && t < 300) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      fft_start = (glitch && addr_mode == 2'd2 && (t % 17 == 5));
      t++;
      @(posedge tb_clk); #1;
    end
    fft_start = 1'b0;
    in_valid  = 1'b0;
    chk("reached_unload", addr_mode, 3);
    t = 0;
    while (done_total == dn_0 && t < 200) begin
      case (or_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = !(t >= 2 && t < 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      t++;
      @(posedge tb_clk); #1;
    end
    out_ready = 1'b0;
    chk("done_count", done_total - dn_0, 1);
    chk("busy_after_done", busy, 0);
    chk("mode_after_done", addr_mode, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("bfly_phase_cycles", mode2_total - m2_0, LOG2N * (N / 2) * (4 + BF_LAT));
    chk("shift_out_count", so_total - so_0, N);
    chk("bfly_ena_count", bf_total - bf_0, LOG2N * N / 2);
    chk("load_write_count", ldw_total - ldw_0, N);
    chk("load_span", ld_last - ld_first, jl - jf);
  endtask

  initial begin
    #3;
    chk("reset_outputs_zero", all_outs(), 0);
    @(posedge tb_clk); #1;
    rst = 1'b0;
    @(posedge tb_clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_mode", addr_mode, 0);

    run_fft(0, 0, 1'b0);
    run_fft(1, 2, 1'b1);
    run_fft(2, 1, 1'b1);
    run_fft(2, 2, 1'b0);

    // Abort in the middle of stage 1, then run a complete FFT.
    begin
      int t;
      push_expected();
      fft_start = 1'b1;
      @(posedge tb_clk); #1;
      fft_start = 1'b0;
      in_valid  = 1'b1;
      t = 0;
      while (!(addr_mode == 2'd2 && stage == 2'd1) && t < 300) begin
        t++;
        @(posedge tb_clk); #1;
      end
      chk("reached_stage1", stage, 1);
      repeat (5) @(posedge tb_clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs_zero", all_outs(), 0);
      @(posedge tb_clk); #1;
      chk("held_reset_outputs_zero", all_outs(), 0);
      exp_q.delete();
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge tb_clk); #1;
      chk("busy_after_release", busy, 0);
      chk("mode_after_release", addr_mode, 0);
    end
    run_fft(0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
